// File: rtl/tile_draw_arbiter_pkg.sv
// Shared constants and state encoding for the tile draw arbiter and its scan counter.
package tile_draw_arbiter_pkg;

    localparam int TILE_W    = 5;
    localparam int TILE_COLS = 32;
    localparam int TILE_ROWS = 24;

    localparam logic [2:0] BG_COLOUR_DEF = 3'b000;
    localparam logic [2:0] SCAN_MAX      = 3'(TILE_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tile_draw_arbiter_scan.sv
// Row-major 5x5 pixel scan counter; last flags pixel (row 4, col 4).
module tile_scan_counter
    import tile_draw_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       clear,
    output logic [2:0] col,
    output logic [2:0] row,
    output logic       last
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (enable) begin
            if (col == SCAN_MAX) begin
                col <= '0;
                row <= (row == SCAN_MAX) ? 3'd0 : row + 3'd1;
            end else begin
                col <= col + 3'd1;
            end
        end
    end

    assign last = (col == SCAN_MAX) && (row == SCAN_MAX);

endmodule

// File: rtl/tile_draw_arbiter.sv
// Round-robin arbiter that grants one requester at a time and draws its 5x5 tile
// as 25 consecutive pixel writes, followed by a one-cycle done pulse.
module tile_draw_arbiter
    import tile_draw_arbiter_pkg::*;
#(
    parameter int         NUM_REQ   = 4,
    parameter logic [2:0] BG_COLOUR = BG_COLOUR_DEF
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [5*NUM_REQ-1:0]   req_tx,
    input  logic [5*NUM_REQ-1:0]   req_ty,
    input  logic [25*NUM_REQ-1:0]  req_shape,
    input  logic [3*NUM_REQ-1:0]   req_colour,
    input  logic                   hold,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic                   busy,
    output logic                   plot,
    output logic [7:0]             x_out,
    output logic [6:0]             y_out,
    output logic [2:0]             colour_out
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e          state;
    state_e          state_next;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   grant_idx;
    logic [IW-1:0]   sel_idx;
    logic            sel_valid;
    logic            grant_now;
    int              idx;
    logic [4:0]      tx_l;
    logic [4:0]      ty_l;
    logic [24:0]     shape_l;
    logic [2:0]      colour_l;
    logic [2:0]      col;
    logic [2:0]      row;
    logic            last;
    logic [4:0]      pix_idx;

    tile_scan_counter u_scan (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (state == ST_DRAW),
        .clear   (state != ST_DRAW),
        .col     (col),
        .row     (row),
        .last    (last)
    );

    // Search starts at rr_ptr and wraps, so the first active index found is the winner.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        idx       = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!sel_valid && req[idx]) begin
                sel_valid = 1'b1;
                sel_idx   = IW'(idx);
            end
        end
    end

    assign grant_now = (state == ST_IDLE) && !hold && sel_valid;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (grant_now) state_next = ST_DRAW;
            ST_DRAW: if (last)      state_next = ST_DONE;
            ST_DONE:                state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Requester inputs are captured once at grant so the draw is immune to later changes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr    <= '0;
            grant_idx <= '0;
            tx_l      <= '0;
            ty_l      <= '0;
            shape_l   <= '0;
            colour_l  <= '0;
        end else if (grant_now) begin
            rr_ptr    <= (int'(sel_idx) == NUM_REQ - 1) ? '0 : sel_idx + IW'(1);
            grant_idx <= sel_idx;
            tx_l      <= req_tx[int'(sel_idx)*5 +: 5];
            ty_l      <= req_ty[int'(sel_idx)*5 +: 5];
            shape_l   <= req_shape[int'(sel_idx)*25 +: 25];
            colour_l  <= req_colour[int'(sel_idx)*3 +: 3];
        end
    end

    assign pix_idx = {2'b00, row} * 5'd5 + {2'b00, col};

    always_comb begin
        grant      = '0;
        done       = '0;
        plot       = 1'b0;
        x_out      = '0;
        y_out      = '0;
        colour_out = '0;
        busy       = (state != ST_IDLE);
        if (state == ST_DRAW) begin
            grant[grant_idx] = 1'b1;
            plot       = (ty_l < 5'(TILE_ROWS));
            x_out      = {3'b000, tx_l} * 8'd5 + {5'b00000, col};
            y_out      = {2'b00, ty_l} * 7'd5 + {4'b0000, row};
            colour_out = shape_l[5'd24 - pix_idx] ? colour_l : BG_COLOUR;
        end else if (state == ST_DONE) begin
            done[grant_idx] = 1'b1;
        end
    end

endmodule

// File: doc/tile_draw_arbiter.md
TILE_DRAW_ARBITER -- requirements
Module: tile_draw_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters; the block SHALL support values 2 to 8.
REQ-002 Parameter BG_COLOUR, 3'b000, colour driven for shape bits equal to 0.
REQ-003 clock  input  1  single clock; all state SHALL change on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester draw request, level, held until done.
REQ-006 req_tx  input  5*NUM_REQ  tile column 0..31 per requester, packed with requester 0 in the LSBs.
REQ-007 req_ty  input  5*NUM_REQ  tile row 0..23 per requester, packed.
REQ-008 req_shape  input  25*NUM_REQ  5x5 bitmap per requester, bit 24 = top-left pixel, row-major.
REQ-009 req_colour  input  3*NUM_REQ  foreground colour per requester.
REQ-010 hold  input  1  when high, no new grant SHALL issue.
REQ-011 grant  output  NUM_REQ  one-hot, high for the full duration of a tile draw.
REQ-012 done  output  NUM_REQ  one-cycle pulse on the requester's bit when its tile finishes.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 plot  output  1  pixel write strobe to the VGA adapter.
REQ-015 x_out  output  8, y_out  output  7, colour_out  output  3  pixel address and colour.

Function
REQ-016 The block SHALL implement the states IDLE, DRAW and DONE.
REQ-017 IDLE: when hold=0 and req is non-zero, the block SHALL select a requester round-robin, latch that requester's tx, ty, shape and colour, and enter DRAW on the next edge.
REQ-018 Round-robin: the search SHALL start at index rr_ptr; after granting index g, rr_ptr SHALL become (g+1) mod NUM_REQ.
REQ-019 DRAW SHALL last exactly 25 cycles, scanning col 0..4 within row 0..4, row-major.
REQ-020 In DRAW: x_out = tx*5+col and y_out = ty*5+row, each computed at full output width without truncation.
REQ-021 In DRAW: colour_out = latched colour if shape[24-(row*5+col)] = 1, otherwise BG_COLOUR.
REQ-022 In DRAW: plot = 1, except that plot SHALL be 0 for all 25 cycles when latched ty > 23; done SHALL still pulse.
REQ-023 After pixel (row 4, col 4), the block SHALL spend one cycle in DONE: done[g] = 1, grant = 0, plot = 0; it SHALL then return to IDLE.
REQ-024 Latency: req sampled in IDLE at cycle N produces grant and the first plot at N+1, the last plot at N+25, done at N+26, and IDLE at N+27.
REQ-025 Requester inputs SHALL be ignored during DRAW; a deassertion of req mid-draw SHALL NOT abort the draw.
REQ-026 A request still high after done SHALL be re-eligible in IDLE, at lowest priority per REQ-018.
REQ-027 A hold rising edge during DRAW SHALL NOT affect the current tile; hold affects only the IDLE grant decision.
REQ-028 When no request is pending or hold=1, the block SHALL stay in IDLE with plot = 0, x_out = 0, y_out = 0 and colour_out = 0.

Reset
REQ-029 When reset_n = 0, state SHALL become IDLE, rr_ptr = 0, all latched registers = 0, and grant, done, busy and plot = 0, immediately and asynchronously.
REQ-030 Reset mid-DRAW SHALL abandon the tile with no done pulse.
REQ-031 The first grant after reset SHALL go to the lowest-indexed active requester.

Structure
REQ-032 A shared package SHALL hold TILE_W = 5, TILE_COLS = 32, TILE_ROWS = 24, the state encoding and BG_COLOUR_DEF.
REQ-033 The col/row scan SHALL be a sub-module tile_scan_counter with enable, clear, col[2:0], row[2:0] and a last flag.
REQ-034 Arbitration, latching and output muxing SHALL remain in tile_draw_arbiter.

Verification
REQ-035 Single draw: req[0] with tx=2, ty=3, shape=25'h1FFFFFF, colour=3'b110 -> 25 plots covering x 10..14 and y 15..19, all colour 6, then done[0] at N+26.
REQ-036 Shape mapping: shape=25'h1000000 -> only pixel (tx*5, ty*5) has colour_out = colour; the other 24 pixels are BG_COLOUR.
REQ-037 Round-robin: req = 4'b1111 held continuously -> grant order 0, 1, 2, 3, 0, with each tile 27 cycles apart.
REQ-038 Boundaries: tx=31, ty=23 -> maximum x_out = 159 and y_out = 119; ty=24 -> no plot, done still pulses.
REQ-039 Hold and reset: hold=1 with req pending -> no grant; reset_n low at DRAW pixel 10 -> plot, grant and busy are 0 at once, no done, and the next grant goes to requester 0.
